vlog_stream_scoreboard: RTL

- Testbench-side checker that sits directly upstream of the TAP generator.
- Captures an expected data stream into an internal FIFO and compares the DUT's actual stream against the FIFO head, beat by beat.
- At each testcase boundary it emits a one-cycle verdict: pass/fail plus counts. The bench forwards this to the TAP writer as an ok/not-ok entry.
- Clocked, synthesizable-style RTL, so it can also run in emulation.

---
 rtl/vlog_sb_pkg.sv | 22 ++
 rtl/vlog_sb_fifo.sv | 60 ++++++
 rtl/vlog_stream_scoreboard.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/vlog_sb_pkg.sv
// Shared types and helpers for the stream scoreboard.
// Optional watchdog is enabled with VLOG_SB_TIMEOUT_EN.
package vlog_sb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        REPORT,
        FLUSH
    } sb_state_t;

    localparam int SB_DEPTH = 16;
    localparam int PTR_W    = $clog2(SB_DEPTH);

    function automatic logic [31:0] sat_inc(
        input logic [31:0] v,
        input logic [31:0] max
    );
        return (v >= max) ? max : v + 32'd1;
    endfunction

endpackage

// File: rtl/vlog_sb_fifo.sv
// Synchronous FIFO holding expected beats, with occupancy count.
// Part of the VLOG_SB_TIMEOUT_EN-configurable stream scoreboard.
module vlog_sb_fifo
    import vlog_sb_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = SB_DEPTH,
    parameter int AW     = PTR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic [AW:0]       count,
    output logic              full,
    output logic              empty
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     wr_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers are AW bits wide, so they wrap modulo DEPTH on their own
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + (AW+1)'(1);
            end else if (do_pop && !do_push) begin
                count <= count - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/vlog_stream_scoreboard.sv
// Compares an actual beat stream against queued expected beats per testcase.
// Define VLOG_SB_TIMEOUT_EN to add the stall watchdog and timeout_o.
module vlog_stream_scoreboard
    import vlog_sb_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = SB_DEPTH,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 1000
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     tc_start_i,
    input  logic                     tc_end_i,
    input  logic                     exp_valid_i,
    output logic                     exp_ready_o,
    input  logic [DATA_W-1:0]        exp_data_i,
    input  logic                     act_valid_i,
    output logic                     act_ready_o,
    input  logic [DATA_W-1:0]        act_data_i,
    output logic                     busy_o,
    output logic                     verdict_valid_o,
    output logic                     verdict_ok_o,
    output logic [CNT_W-1:0]         beats_o,
    output logic [CNT_W-1:0]         errors_o,
    output logic [$clog2(DEPTH):0]   leftover_o
`ifdef VLOG_SB_TIMEOUT_EN
    ,
    output logic                     timeout_o
`endif
);

    localparam int          LW      = $clog2(DEPTH) + 1;
    localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_param
        $error("vlog_stream_scoreboard: DEPTH must be a power of 2 >= 2, TIMEOUT >= 1");
    end

    sb_state_t         state;
    sb_state_t         state_nx;
    logic [DATA_W-1:0] head;
    logic [LW-1:0]     count;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              act_fire;
    logic              bad;
    logic              wd_hit;
    logic              timed_out;
    logic [CNT_W-1:0]  beats;
    logic [CNT_W-1:0]  errors;
    logic [LW-1:0]     left_q;

    vlog_sb_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     ($clog2(DEPTH))
    ) u_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .push  (push),
        .pop   (pop),
        .wdata (exp_data_i),
        .rdata (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    assign act_fire = act_valid_i && (state == RUN);
    // No bypass: an empty FIFO means the beat is unexpected even if a push lands now
    assign bad      = act_fire && (empty || head != act_data_i);

    always_comb begin
        state_nx        = state;
        pop             = 1'b0;
        exp_ready_o     = ((state == IDLE) || (state == RUN)) && !full;
        push            = exp_valid_i && exp_ready_o;
        act_ready_o     = (state == RUN);
        busy_o          = (state == RUN);
        verdict_valid_o = (state == REPORT);
        verdict_ok_o    = (state == REPORT) && (errors == '0)
                          && (count == '0) && !timed_out;
        leftover_o      = (state == REPORT) ? count : left_q;
        beats_o         = beats;
        errors_o        = errors;
        unique case (state)
            IDLE: begin
                if (tc_start_i) state_nx = RUN;
            end
            RUN: begin
                pop = act_fire && !empty;
                if (tc_end_i || wd_hit) state_nx = REPORT;
            end
            REPORT: begin
                state_nx = FLUSH;
            end
            FLUSH: begin
                pop = !empty;
                if (count <= LW'(1)) state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= IDLE;
            beats  <= '0;
            errors <= '0;
            left_q <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && tc_start_i) begin
                beats  <= '0;
                errors <= '0;
                left_q <= '0;
            end
            if (act_fire) begin
                beats <= CNT_W'(sat_inc(32'(beats), CNT_MAX));
            end
            if (bad) begin
                errors <= CNT_W'(sat_inc(32'(errors), CNT_MAX));
            end
            if (state == REPORT) begin
                left_q <= count;
            end
        end
    end

`ifdef VLOG_SB_TIMEOUT_EN
    logic [31:0] wd;
    logic        to_q;

    // Counts only stalled cycles: data is queued but the DUT sends nothing
    assign wd_hit    = (state == RUN) && !act_fire && !empty
                       && (wd == 32'(TIMEOUT - 1));
    assign timed_out = to_q;
    assign timeout_o = (state == REPORT) && to_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wd   <= '0;
            to_q <= 1'b0;
        end else begin
            if (state != RUN || act_fire) begin
                wd <= '0;
            end else if (!empty) begin
                wd <= wd + 32'd1;
            end
            if (state == IDLE) begin
                to_q <= 1'b0;
            end else if (wd_hit) begin
                to_q <= 1'b1;
            end
        end
    end
`else
    assign wd_hit    = 1'b0;
    assign timed_out = 1'b0;
`endif

endmodule
